// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR stream generator: FSM encoding, size limit
// and a table of primitive feedback masks indexed by register width.
package lfsr_pkg;

  localparam int LFSR_MAX_N = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_LOCKED = 2'd2
  } lfsr_fsm_e;

  // Mask bit k-1 selects stage k; polynomial x^n + sum(x^k) + 1 maps to bit 0 plus bit k per term.
  function automatic logic [LFSR_MAX_N-1:0] default_taps(input int n);
    logic [LFSR_MAX_N-1:0] m;
    m = 32'h0000_0003;
    case (n)
      2:  m = 32'h0000_0003;
      3:  m = 32'h0000_0005;
      4:  m = 32'h0000_0009;
      5:  m = 32'h0000_0009;
      6:  m = 32'h0000_0021;
      7:  m = 32'h0000_0041;
      8:  m = 32'h0000_0071;
      9:  m = 32'h0000_0021;
      10: m = 32'h0000_0081;
      11: m = 32'h0000_0201;
      12: m = 32'h0000_0053;
      13: m = 32'h0000_001B;
      14: m = 32'h0000_002B;
      15: m = 32'h0000_4001;
      16: m = 32'h0000_6801;
      17: m = 32'h0000_4001;
      18: m = 32'h0000_0801;
      19: m = 32'h0000_0047;
      20: m = 32'h0002_0001;
      21: m = 32'h0008_0001;
      22: m = 32'h0020_0001;
      23: m = 32'h0004_0001;
      24: m = 32'h00C2_0001;
      25: m = 32'h0040_0001;
      26: m = 32'h0000_0047;
      27: m = 32'h0000_0027;
      28: m = 32'h0200_0001;
      29: m = 32'h0800_0001;
      30: m = 32'h0000_0053;
      31: m = 32'h1000_0001;
      32: m = 32'h0040_0007;
      default: m = 32'h0000_0003;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// One Fibonacci LFSR step: feedback enters the top stage, stage 1 is shifted out.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] state_in,
  input  logic [N-1:0] taps,
  output logic [N-1:0] next_state,
  output logic         out_bit
);

  logic w_fb;

  assign w_fb       = ^(state_in & taps);
  assign next_state = {w_fb, state_in[N-1:1]};
  assign out_bit    = state_in[0];

endmodule

// File: rtl/lfsr_stream_gen.sv
// PRBS source: W-bit chunks over valid/ready, runtime taps, lockup detection
// and period measurement against the most recently loaded seed.
module lfsr_stream_gen
  import lfsr_pkg::*;
#(
  parameter int             N            = 16,
  parameter int             W            = 1,
  parameter logic [N-1:0]   DEFAULT_TAPS = N'(default_taps(N)),
  parameter int             CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     seed_value,
  input  logic             load_seed,
  input  logic [N-1:0]     taps_value,
  input  logic             load_taps,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [N-1:0]     state_value,
  output logic             lockup,
  output logic             period_done,
  output logic [CNT_W-1:0] period_len
);

  lfsr_fsm_e        r_fsm;
  lfsr_fsm_e        w_fsm_nxt;
  logic [N-1:0]     r_state;
  logic [N-1:0]     r_taps;
  logic [N-1:0]     r_seed_ref;
  logic [CNT_W-1:0] r_step_count;
  logic [CNT_W-1:0] r_period_len;
  logic             r_period_done;

  logic [W:0][N-1:0] w_chain;
  logic [W-1:0]      w_bits;
  logic [N-1:0]      w_adv;
  logic              w_xfer;
  logic [CNT_W:0]    w_sum_ext;
  logic [CNT_W-1:0]  w_step_sat;

  // W single steps chained so a whole chunk advances in one cycle.
  assign w_chain[0] = r_state;
  for (genvar g = 0; g < W; g++) begin : g_step
    lfsr_step #(.N(N)) u_step (
      .state_in   (w_chain[g]),
      .taps       (r_taps),
      .next_state (w_chain[g+1]),
      .out_bit    (w_bits[g])
    );
  end
  assign w_adv = w_chain[W];

  assign w_xfer     = (r_fsm == ST_RUN) & out_ready;
  assign w_sum_ext  = {1'b0, r_step_count} + (CNT_W+1)'(W);
  assign w_step_sat = w_sum_ext[CNT_W] ? '1 : w_sum_ext[CNT_W-1:0];

  always_comb begin
    w_fsm_nxt = r_fsm;
    if (load_seed) begin
      w_fsm_nxt = (seed_value != '0) ? ST_RUN : ST_LOCKED;
    end else if (w_xfer && (w_adv == '0)) begin
      w_fsm_nxt = ST_LOCKED;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_fsm <= ST_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= '0;
      r_taps        <= DEFAULT_TAPS;
      r_seed_ref    <= '0;
      r_step_count  <= '0;
      r_period_len  <= '0;
      r_period_done <= 1'b0;
    end else begin
      r_period_done <= 1'b0;
      if (load_taps) r_taps <= taps_value;
      // A seed load overrides the advance even when the handshake completes.
      if (load_seed) begin
        r_state      <= seed_value;
        r_seed_ref   <= seed_value;
        r_step_count <= '0;
      end else if (w_xfer) begin
        r_state <= w_adv;
        if (w_adv == r_seed_ref) begin
          r_period_done <= 1'b1;
          r_period_len  <= w_step_sat;
          r_step_count  <= '0;
        end else begin
          r_step_count <= w_step_sat;
        end
      end
    end
  end

  assign out_valid   = (r_fsm == ST_RUN);
  assign lockup      = (r_fsm == ST_LOCKED);
  assign out_data    = w_bits;
  assign state_value = r_state;
  assign period_done = r_period_done;
  assign period_len  = r_period_len;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: two N=4 instances (W=1 and W=4) on shared stimulus,
// checked every cycle against a bit-stream recurrence model plus directed constants.
module tb_lfsr_stream_gen;

  localparam int N = 4;
  localparam int WK [2] = '{1, 4};
  localparam int M_IDLE = 0, M_RUN = 1, M_LOCKED = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] seed_value = '0, taps_value = '0;
  logic load_seed = 1'b0, load_taps = 1'b0, out_ready = 1'b0;

  logic v1, lk1, pd1, v4, lk4, pd4;
  logic [0:0] d1;
  logic [3:0] d4, s1, s4;
  logic [31:0] pl1, pl4;

  always #5 clk = ~clk;

  lfsr_stream_gen #(.N(N), .W(1), .DEFAULT_TAPS(4'b0011), .CNT_W(32)) u_dut1 (
    .clk(clk), .reset(reset), .seed_value(seed_value), .load_seed(load_seed),
    .taps_value(taps_value), .load_taps(load_taps), .out_ready(out_ready),
    .out_valid(v1), .out_data(d1), .state_value(s1), .lockup(lk1),
    .period_done(pd1), .period_len(pl1));

  lfsr_stream_gen #(.N(N), .W(4), .DEFAULT_TAPS(4'b0011), .CNT_W(32)) u_dut4 (
    .clk(clk), .reset(reset), .seed_value(seed_value), .load_seed(load_seed),
    .taps_value(taps_value), .load_taps(load_taps), .out_ready(out_ready),
    .out_valid(v4), .out_data(d4), .state_value(s4), .lockup(lk4),
    .period_done(pd4), .period_len(pl4));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: the register is a window onto the bit stream s[t],
  // with s[t+N] = XOR of s[t+i] over every tapped stage i+1.
  logic [3:0] m_st [2], m_taps [2], m_ref [2];
  int         m_mode [2];
  longint     m_step [2], m_plen [2];
  bit         m_pd [2];

  function automatic logic [3:0] stream_advance(logic [3:0] st, logic [3:0] tp, int w);
    bit s [N+4];
    logic [3:0] r;
    for (int i = 0; i < N + 4; i++) s[i] = 1'b0;
    for (int i = 0; i < N; i++) s[i] = st[i];
    for (int t = 0; t < w; t++) begin
      bit b = 1'b0;
      for (int i = 0; i < N; i++) if (tp[i]) b ^= s[t+i];
      s[t+N] = b;
    end
    for (int i = 0; i < N; i++) r[i] = s[w+i];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = '0; m_taps[k] = 4'b0011; m_ref[k] = '0; m_mode[k] = M_IDLE;
      m_step[k] = 0; m_plen[k] = 0; m_pd[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit ls, input logic [3:0] sv, input bit lt,
                            input logic [3:0] tv, input bit rdy);
    for (int k = 0; k < 2; k++) begin
      logic [3:0] nxt;
      longint sum;
      m_pd[k] = 1'b0;
      if (ls) begin
        m_st[k] = sv; m_ref[k] = sv; m_step[k] = 0;
        m_mode[k] = (sv != 0) ? M_RUN : M_LOCKED;
      end else if (m_mode[k] == M_RUN && rdy) begin
        nxt = stream_advance(m_st[k], m_taps[k], WK[k]);
        sum = m_step[k] + WK[k];
        if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
        m_st[k] = nxt;
        if (nxt == 0) m_mode[k] = M_LOCKED;
        if (nxt == m_ref[k]) begin
          m_pd[k] = 1'b1; m_plen[k] = sum; m_step[k] = 0;
        end else begin
          m_step[k] = sum;
        end
      end
      if (lt) m_taps[k] = tv;
    end
  endtask

  task automatic compare_all();
    chk("valid_w1",  v1,  m_mode[0] == M_RUN);
    chk("lockup_w1", lk1, m_mode[0] == M_LOCKED);
    chk("data_w1",   d1,  m_st[0][0]);
    chk("state_w1",  s1,  m_st[0]);
    chk("pdone_w1",  pd1, m_pd[0]);
    chk("plen_w1",   pl1, m_plen[0][31:0]);
    chk("valid_w4",  v4,  m_mode[1] == M_RUN);
    chk("lockup_w4", lk4, m_mode[1] == M_LOCKED);
    chk("data_w4",   d4,  m_st[1]);
    chk("state_w4",  s4,  m_st[1]);
    chk("pdone_w4",  pd4, m_pd[1]);
    chk("plen_w4",   pl4, m_plen[1][31:0]);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit ls, input logic [3:0] sv, input bit lt,
                      input logic [3:0] tv, input bit rdy);
    compare_all();
    load_seed = ls; seed_value = sv; load_taps = lt; taps_value = tv; out_ready = rdy;
    model_edge(ls, sv, lt, tv, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset();
    load_seed = 1'b0; load_taps = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_valid",  {v1, v4},   2'b00);
    chk("rst_lockup", {lk1, lk4}, 2'b00);
    chk("rst_pdone",  {pd1, pd4}, 2'b00);
    chk("rst_state",  {s1, s4},   8'h00);
    chk("rst_data",   {d1, d4},   5'h00);
    chk("rst_plen",   pl1 | pl4,  32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  bit exp_bits [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("init_valid", v1, 1'b0);
    chk("init_state", s4, 4'h0);

    // x^4+x+1 from seed 0001: first bits and period.
    step(1, 4'b0001, 1, 4'b0011, 1);
    for (int i = 0; i < 15; i++) begin
      if (i < 5) chk("t1_bit", d1, exp_bits[i]);
      if (i == 0) chk("t2_data0", d4, 4'b0001);
      if (i == 1) begin
        chk("t2_state1", s4, 4'b1001);
        chk("t2_data1",  d4, 4'b1001);
      end
      step(0, 0, 0, 0, 1);
    end
    chk("t1_pdone", pd1, 1'b1);
    chk("t1_plen",  pl1, 32'd15);
    chk("t2_pdone", pd4, 1'b1);
    chk("t2_plen",  pl4, 32'd60);

    // Stall mid-run.
    repeat (3) step(0, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0, 1);

    // Seed load coincident with a transfer.
    step(1, 4'b0110, 0, 0, 1);
    chk("t6_seed_w1", s1, 4'b0110);
    chk("t6_seed_w4", s4, 4'b0110);

    // Zero seed then recovery.
    step(1, 4'b0000, 0, 0, 0);
    chk("t3_lock",   {lk1, lk4}, 2'b11);
    chk("t3_valid",  {v1, v4},   2'b00);
    step(1, 4'b0101, 0, 0, 0);
    chk("t3_unlock", {lk1, lk4}, 2'b00);
    chk("t3_run",    {v1, v4},   2'b11);
    chk("t3_state",  s1, 4'b0101);

    // Taps without stage 1 collapse to zero.
    step(1, 4'b0001, 1, 4'b1100, 1);
    step(0, 0, 0, 0, 1);
    chk("t4_state", {s1, s4},   8'h00);
    chk("t4_lock",  {lk1, lk4}, 2'b11);
    chk("t4_valid", {v1, v4},   2'b00);

    // Reset in the middle of a run.
    step(1, 4'b1001, 1, 4'b0011, 1);
    repeat (5) step(0, 0, 0, 0, 1);
    async_reset();

    for (int c = 0; c < 3000; c++) begin
      bit ls, lt, rdy;
      logic [3:0] sv, tv;
      int sel;
      ls  = ($urandom_range(0, 99) < 4);
      sv  = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      lt  = ($urandom_range(0, 99) < 3);
      sel = $urandom_range(0, 3);
      tv  = (sel == 0) ? 4'b0011 : (sel == 1) ? 4'b1001 : 4'($urandom_range(0, 15));
      rdy = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 999) < 2) async_reset();
      else step(ls, sv, lt, tv, rdy);
    end
    compare_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
